// File: rtl/fetch_pc_sequencer.sv
// PC/nPC sequencer feeding the IF/ID register: delayed-branch redirects and delay-slot annul.
// Define FETCH_PERF_CNT_EN to add saturating redirect_cnt / annul_cnt event counters.
module fetch_pc_sequencer #(
   parameter int                    ADDR_WIDTH = 8,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
   parameter int                    CNT_WIDTH  = 16
) (
   input  logic                  Clk,
   input  logic                  R,
   input  logic                  LE,
   input  logic                  ID_B_instr,
   input  logic                  ID_29_a,
   input  logic                  ID_ba,
   input  logic                  cond_true,
   input  logic                  ID_Call_instr,
   input  logic                  ID_jmpl_instr,
   input  logic [ADDR_WIDTH-1:0] branch_target,
   input  logic [ADDR_WIDTH-1:0] jmpl_target,
   output logic [ADDR_WIDTH-1:0] PC_Out,
   output logic [ADDR_WIDTH-1:0] nPC_Out,
   output logic                  annul_out,
   output logic                  redirect_out
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [CNT_WIDTH-1:0]  redirect_cnt,
   output logic [CNT_WIDTH-1:0]  annul_cnt
`endif
);

   typedef enum logic {
      RUN   = 1'b0,
      ANNUL = 1'b1
   } state_t;

   localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(3);
   localparam logic [ADDR_WIDTH-1:0] STEP       = ADDR_WIDTH'(4);

   state_t                  state_q, state_d;
   logic [ADDR_WIDTH-1:0]   pc_q, pc_d;
   logic [ADDR_WIDTH-1:0]   npc_q, npc_d;
   logic                    eff;
   logic                    redirect;
   logic                    annul_req;
   logic [ADDR_WIDTH-1:0]   target_raw;
   logic [ADDR_WIDTH-1:0]   target;

   always_comb begin
      eff        = (state_q == RUN);
      redirect   = eff & (ID_jmpl_instr | ID_Call_instr | (ID_B_instr & cond_true));
      annul_req  = eff & ID_B_instr & ID_29_a & (ID_ba | ~cond_true);
      // call and Bicc share branch_target, so only jmpl needs to win the select
      target_raw = ID_jmpl_instr ? jmpl_target : branch_target;
      target     = target_raw & ALIGN_MASK;
      pc_d       = npc_q;
      npc_d      = redirect ? target : npc_q + STEP;
      state_d    = annul_req ? ANNUL : RUN;
   end

   always_ff @(posedge Clk or negedge R) begin
      if (!R) begin
         state_q <= RUN;
         pc_q    <= RESET_PC;
         npc_q   <= RESET_PC + STEP;
      end else if (LE) begin
         state_q <= state_d;
         pc_q    <= pc_d;
         npc_q   <= npc_d;
      end
   end

   assign PC_Out       = pc_q;
   assign nPC_Out      = npc_q;
   assign annul_out    = (state_q == ANNUL);
   assign redirect_out = redirect & LE;

`ifdef FETCH_PERF_CNT_EN
   logic [CNT_WIDTH-1:0] redirect_cnt_q;
   logic [CNT_WIDTH-1:0] annul_cnt_q;

   // Counters stick at all-ones rather than wrapping
   always_ff @(posedge Clk or negedge R) begin
      if (!R) begin
         redirect_cnt_q <= '0;
         annul_cnt_q    <= '0;
      end else if (LE) begin
         if (redirect && (redirect_cnt_q != '1))
            redirect_cnt_q <= redirect_cnt_q + CNT_WIDTH'(1);
         if (annul_req && (annul_cnt_q != '1))
            annul_cnt_q <= annul_cnt_q + CNT_WIDTH'(1);
      end
   end

   assign redirect_cnt = redirect_cnt_q;
   assign annul_cnt    = annul_cnt_q;
`endif

endmodule
